// File: rtl/spi_shift_eng.sv
// SPI host serial data engine: parallel-loads a word, shifts it out on s_out and
// shifts s_in back into the same register on strobes from the SPI clock generator.
module spi_shift_eng #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              latch,
   input  logic [DATA_W-1:0] p_in,
   input  logic [LEN_W-1:0]  len,
   input  logic              lsb,
   input  logic              tx_negedge,
   input  logic              rx_negedge,
   input  logic              go,
   input  logic              pos_edge,
   input  logic              neg_edge,
   input  logic              s_in,
   output logic              s_out,
   output logic              tip,
   output logic              last,
   output logic              done,
   output logic [DATA_W-1:0] p_out
);

   localparam int CNT_W = LEN_W + 1;

   logic [DATA_W-1:0] data_q, data_d;
   logic              s_out_q, s_out_d;
   logic              tip_q, tip_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0]  len_q, len_d;

   logic [CNT_W-1:0]  len_eff;
   logic [DATA_W-1:0] load_word;
   logic              tx_clk;
   logic              rx_clk;

   // Register bit position visited by the k-th serial bit of an l-bit transfer.
   function automatic logic [LEN_W-1:0] bit_idx(input logic [CNT_W-1:0] k,
                                                input logic [CNT_W-1:0] l,
                                                input logic             lsb_first);
      logic [CNT_W-1:0] r;
      r = lsb_first ? k : (l - k - CNT_W'(1));
      return r[LEN_W-1:0];
   endfunction

   assign len_eff   = (len == '0) ? CNT_W'(DATA_W) : {1'b0, len};
   assign load_word = latch ? p_in : data_q;
   assign tx_clk    = tx_negedge ? neg_edge : pos_edge;
   assign rx_clk    = rx_negedge ? neg_edge : pos_edge;

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
      data_d   = data_q;
      s_out_d  = s_out_q;
      tip_d    = tip_q;
      done_d   = 1'b0;
      tx_cnt_d = tx_cnt_q;
      rx_cnt_d = rx_cnt_q;
      len_d    = len_q;

      if (!tip_q) begin
         if (latch) begin
            data_d = p_in;
         end
         if (go) begin
            tip_d    = 1'b1;
            tx_cnt_d = CNT_W'(1);
            rx_cnt_d = '0;
            len_d    = len_eff;
            s_out_d  = load_word[bit_idx(CNT_W'(0), len_eff, lsb)];
         end
      end else begin
         // The tx read below sees data_q, so a shared strobe reads before the rx write lands.
         if (tx_clk && (tx_cnt_q < len_q)) begin
            s_out_d  = data_q[bit_idx(tx_cnt_q, len_q, lsb)];
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
         end
         if (rx_clk) begin
            data_d[bit_idx(rx_cnt_q, len_q, lsb)] = s_in;
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
            if (rx_cnt_q == (len_q - CNT_W'(1))) begin
               tip_d  = 1'b0;
               done_d = 1'b1;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q   <= '0;
         s_out_q  <= 1'b0;
         tip_q    <= 1'b0;
         done_q   <= 1'b0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         len_q    <= '0;
      end else begin
         data_q   <= data_d;
         s_out_q  <= s_out_d;
         tip_q    <= tip_d;
         done_q   <= done_d;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         len_q    <= len_d;
      end
   end

   assign s_out = s_out_q;
   assign tip   = tip_q;
   assign done  = done_q;
   assign p_out = data_q;
   assign last  = tip_q && (tx_cnt_q == len_q);

endmodule

// File: tb/tb_spi_shift_eng.sv
// Bench for spi_shift_eng: directed and random transfers against a bit-list reference model.
module tb_spi_shift_eng;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 5;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              latch;
   logic [DATA_W-1:0] p_in;
   logic [LEN_W-1:0]  len;
   logic              lsb;
   logic              tx_negedge;
   logic              rx_negedge;
   logic              go;
   logic              pos_edge;
   logic              neg_edge;
   logic              s_in;
   logic              s_out;
   logic              tip;
   logic              last;
   logic              done;
   logic [DATA_W-1:0] p_out;

   logic              loop_en;
   logic              s_in_r;

   int n_vec = 0;
   int n_err = 0;

   assign s_in = loop_en ? s_out : s_in_r;

   always #5 clk_i = ~clk_i;

   spi_shift_eng #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .latch      (latch),
      .p_in       (p_in),
      .len        (len),
      .lsb        (lsb),
      .tx_negedge (tx_negedge),
      .rx_negedge (rx_negedge),
      .go         (go),
      .pos_edge   (pos_edge),
      .neg_edge   (neg_edge),
      .s_in       (s_in),
      .s_out      (s_out),
      .tip        (tip),
      .last       (last),
      .done       (done),
      .p_out      (p_out)
   );

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   // Position in the word of serial bit k for an l-bit transfer.
   function automatic int bidx(input int k, input int l, input logic lsb_first);
      return lsb_first ? k : (l - 1 - k);
   endfunction

   // sin_mode: 0 random bits, 1 loopback, 2 constant 0, 3 constant 1.
   task automatic run_xfer(input logic [DATA_W-1:0] word, input logic [LEN_W-1:0] len_v,
                           input logic lsb_v, input logic txn, input logic rxn,
                           input int sin_mode, input logic same_cycle, input int inject_at);
      int                L;
      int                ntx;
      int                nrx;
      logic [DATA_W-1:0] rxw;
      logic              exp_sout;
      logic              sbit;
      logic              is_pos;
      logic              txs;
      logic              rxs;
      L          = (len_v == '0) ? DATA_W : int'(len_v);
      len        = len_v;
      lsb        = lsb_v;
      tx_negedge = txn;
      rx_negedge = rxn;
      loop_en    = (sin_mode == 1);
      p_in       = word;
      if (!same_cycle) begin
         latch = 1'b1;
         tick();
         latch = 1'b0;
         check_word("latch_pout", p_out, word);
      end
      latch = same_cycle;
      go    = 1'b1;
      tick();
      go    = 1'b0;
      latch = 1'b0;
      p_in  = ~word;
      len   = ~len_v;
      rxw      = word;
      ntx      = 0;
      nrx      = 0;
      exp_sout = word[bidx(0, L, lsb_v)];
      check_bit("go_tip", tip, 1'b1);
      check_bit("go_sout", s_out, exp_sout);
      check_bit("go_last", last, L == 1);
      for (int s = 0; s < 4 * L + 4 && nrx < L; s++) begin
         is_pos = (s % 2 == 0);
         txs    = txn ? !is_pos : is_pos;
         rxs    = rxn ? !is_pos : is_pos;
         if (s == inject_at) begin
            p_in  = '1;
            go    = 1'b1;
            latch = 1'b1;
            tick();
            go    = 1'b0;
            latch = 1'b0;
         end
         case (sin_mode)
            0:       sbit = 1'($urandom_range(0, 1));
            1:       sbit = exp_sout;
            2:       sbit = 1'b0;
            default: sbit = 1'b1;
         endcase
         s_in_r   = sbit;
         pos_edge = is_pos;
         neg_edge = !is_pos;
         tick();
         pos_edge = 1'b0;
         neg_edge = 1'b0;
         if (rxs) begin
            rxw[bidx(nrx, L, lsb_v)] = sbit;
            nrx++;
         end
         if (txs && ntx + 1 < L) begin
            ntx++;
            exp_sout = word[bidx(ntx, L, lsb_v)];
         end
         check_bit("step_sout", s_out, exp_sout);
         check_bit("step_tip", tip, nrx < L);
         check_bit("step_last", last, (nrx < L) && (ntx + 1 == L));
         check_bit("step_done", done, nrx == L);
      end
      check_word("end_pout", p_out, rxw);
      tick();
      check_bit("done_gone", done, 1'b0);
      check_bit("hold_sout", s_out, exp_sout);
      check_word("hold_pout", p_out, rxw);
      loop_en = 1'b0;
   endtask

   initial begin
      rst_ni     = 1'b0;
      latch      = 1'b0;
      p_in       = '0;
      len        = '0;
      lsb        = 1'b0;
      tx_negedge = 1'b0;
      rx_negedge = 1'b0;
      go         = 1'b0;
      pos_edge   = 1'b0;
      neg_edge   = 1'b0;
      s_in_r     = 1'b0;
      loop_en    = 1'b0;
      tick();
      tick();
      check_bit("rst_tip", tip, 1'b0);
      check_bit("rst_last", last, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_sout", s_out, 1'b0);
      check_word("rst_pout", p_out, '0);
      rst_ni = 1'b1;
      tick();

      // Reset asserted mid-transfer, L=8.
      p_in = 32'h0000_00FF;
      len  = 5'd8;
      tx_negedge = 1'b1;
      latch = 1'b1;
      go    = 1'b1;
      tick();
      latch = 1'b0;
      go    = 1'b0;
      pos_edge = 1'b1;
      tick();
      pos_edge = 1'b0;
      neg_edge = 1'b1;
      tick();
      neg_edge = 1'b0;
      check_bit("pre_rst_tip", tip, 1'b1);
      #2 rst_ni = 1'b0;
      #1;
      check_bit("arst_tip", tip, 1'b0);
      check_bit("arst_last", last, 1'b0);
      check_bit("arst_done", done, 1'b0);
      check_bit("arst_sout", s_out, 1'b0);
      check_word("arst_pout", p_out, '0);
      tick();
      rst_ni = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pos_edge = (i % 2 == 0);
         neg_edge = (i % 2 == 1);
         tick();
         check_bit("idle_done", done, 1'b0);
         check_bit("idle_tip", tip, 1'b0);
         check_word("idle_pout", p_out, '0);
      end
      pos_edge = 1'b0;
      neg_edge = 1'b0;

      // Loopback, tx on neg_edge, rx on pos_edge, MSB first, 8 bits of 0xA5.
      run_xfer(32'h0000_00A5, 5'd8, 1'b0, 1'b1, 1'b0, 1, 1'b0, -1);
      check_word("t2_pout", p_out & 32'h0000_00FF, 32'h0000_00A5);

      // LSB first, 32 bits, s_in held high.
      run_xfer(32'h0000_0001, 5'd0, 1'b1, 1'b1, 1'b0, 3, 1'b0, -1);
      check_word("t3_pout", p_out, 32'hFFFF_FFFF);

      // go and latch pulsed mid-transfer must be ignored.
      run_xfer(32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 9);
      check_word("t4_pout", p_out, 32'h1234_5678);

      // latch and go together: first bit comes from p_in, not the old register.
      p_in  = 32'h0000_0001;
      latch = 1'b1;
      tick();
      latch = 1'b0;
      run_xfer(32'h0000_0080, 5'd8, 1'b0, 1'b1, 1'b0, 0, 1'b1, -1);

      // Same-edge mode, single bit.
      run_xfer(32'h0000_0001, 5'd1, 1'b0, 1'b0, 1'b0, 2, 1'b0, -1);
      check_bit("t6_pout0", p_out[0], 1'b0);

      for (int t = 0; t < 24; t++) begin
         run_xfer($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
